sample_out_ctrl: RTL and testbench

Output-side controller for the reverberation processor. It captures the processor's `write`/`Data` sample strobes during a run and tags each with the channel chosen by `modeSelector` (0 → OUT1, 1 → OUT2). Samples are buffered in a small FIFO and drained to the downstream sink (file writer, UART or memory) over a valid/ready handshake. It sequences one run of `n_samples`, back-pressures the processor when the buffer is full, and reports completion.

---
 rtl/reverb_pkg.sv | 19 +
 rtl/sample_fifo.sv | 56 +++++
 rtl/sample_out_ctrl.sv | 130 +++++++++++++
 tb/tb_sample_out_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reverb_pkg.sv
// Shared types and default sizes for the reverberation processor output path.
package reverb_pkg;

   localparam int SAMPLE_W       = 32;
   localparam int OUT_FIFO_DEPTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } ctrl_state_e;

   typedef enum logic {
      CHAN_OUT1 = 1'b0,
      CHAN_OUT2 = 1'b1
   } chan_e;

endpackage

// File: rtl/sample_fifo.sv
// Registered-storage FIFO with first-word-fall-through head and synchronous flush.
module sample_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             push_ok;
   logic             pop_ok;

   // A push while full is refused even when a pop frees a slot in the same cycle.
   assign full    = (cnt == FULL_CNT);
   assign empty   = (cnt == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr];
   assign count   = cnt;

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && rst && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/sample_out_ctrl.sv
// Output-side run controller: tags processor samples with a channel, buffers them
// and drains them to the sink over valid/ready, counting deliveries per channel.
module sample_out_ctrl
   import reverb_pkg::*;
#(
   parameter int DATA_W = SAMPLE_W,
   parameter int DEPTH  = OUT_FIFO_DEPTH,
   parameter int CNT_W  = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              modeSelector,
   input  logic [CNT_W-1:0]  n_samples,
   input  logic              write,
   input  logic [DATA_W-1:0] Data,
   output logic              stall,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_chan,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [CNT_W-1:0]  cnt_out1,
   output logic [CNT_W-1:0]  cnt_out2,
   output logic [1:0]        dbg_state
);

   // Sink handshake: a sample transfers on any rising edge where out_valid && out_ready;
   // out_valid never drops and out_data/out_chan never change until that transfer happens.

   localparam int AW = $clog2(DEPTH);

   ctrl_state_e        state;
   ctrl_state_e        state_next;
   chan_e              run_mode;
   logic [CNT_W-1:0]   run_len;
   logic [CNT_W-1:0]   accepted;
   logic               len_reached;
   logic               f_push;
   logic               f_pop;
   logic               f_full;
   logic               f_empty;
   logic [DATA_W:0]    f_rdata;
   logic [AW:0]        f_count;
   logic               drop;
   logic               start_ok;

   assign len_reached = (accepted == run_len);
   assign start_ok    = (state == IDLE) && start && !abort;
   assign f_push      = (state == RUN) && write && !f_full && !len_reached && !abort;
   assign drop        = (state == RUN) && write &&  f_full && !len_reached && !abort;
   assign f_pop       = out_valid && out_ready && !abort;

   assign stall     = (f_count == (AW+1)'(DEPTH));
   assign out_valid = !f_empty;
   // Gate the head with valid so idle/reset output is zero rather than stale storage.
   assign out_data  = out_valid ? f_rdata[DATA_W-1:0] : '0;
   assign out_chan  = out_valid & f_rdata[DATA_W];
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign dbg_state = state;

   sample_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (abort),
      .push  (f_push),
      .wdata ({run_mode, Data}),
      .pop   (f_pop),
      .rdata (f_rdata),
      .full  (f_full),
      .empty (f_empty),
      .count (f_count)
   );

   always_comb begin
      state_next = state;
      if (abort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (start)       state_next = RUN;
            RUN:     if (len_reached) state_next = DRAIN;
            DRAIN:   if (f_empty)     state_next = DONE;
            DONE:                     state_next = IDLE;
            default:                  state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         run_mode <= CHAN_OUT1;
         run_len  <= '0;
         accepted <= '0;
         cnt_out1 <= '0;
         cnt_out2 <= '0;
         overflow <= 1'b0;
      end else begin
         state <= state_next;
         if (start_ok) begin
            run_mode <= chan_e'(modeSelector);
            run_len  <= n_samples;
            accepted <= '0;
            cnt_out1 <= '0;
            cnt_out2 <= '0;
            overflow <= 1'b0;
         end else begin
            if (f_push) accepted <= accepted + CNT_W'(1);
            if (drop)   overflow <= 1'b1;
            // Delivery counters saturate instead of wrapping.
            if (f_pop) begin
               if (chan_e'(f_rdata[DATA_W]) == CHAN_OUT2) begin
                  if (cnt_out2 != '1) cnt_out2 <= cnt_out2 + CNT_W'(1);
               end else begin
                  if (cnt_out1 != '1) cnt_out1 <= cnt_out1 + CNT_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sample_out_ctrl.sv
// Directed bench for sample_out_ctrl: scenario tasks with inline checks plus a
// delivery scoreboard fed from an expected queue of {chan, data} words.
module tb_sample_out_ctrl;
   import reverb_pkg::*;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 8;
   localparam int CNT_W  = 20;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              abort;
   logic              mode_sel;
   logic [CNT_W-1:0]  n_samples;
   logic              write;
   logic [DATA_W-1:0] data;
   logic              stall;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_chan;
   logic              busy;
   logic              done;
   logic              overflow;
   logic [CNT_W-1:0]  cnt_out1;
   logic [CNT_W-1:0]  cnt_out2;
   logic [1:0]        dbg_state;

   logic [DATA_W:0]   exp_q[$];
   logic [DATA_W:0]   sb_exp;
   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;

   sample_out_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .modeSelector(mode_sel),
      .n_samples(n_samples), .write(write), .Data(data), .stall(stall),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_chan(out_chan), .busy(busy), .done(done), .overflow(overflow),
      .cnt_out1(cnt_out1), .cnt_out2(cnt_out2), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Scoreboard: every accepted transfer must match the oldest expected word.
   always @(negedge clk) begin
      if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected got chan=%0d data=%h, expected no transfer", out_chan, out_data);
         end else begin
            sb_exp = exp_q.pop_front();
            if ({out_chan, out_data} !== sb_exp) begin
               failures++;
               $display("FAIL sb_data got chan=%0d data=%h, expected chan=%0d data=%h",
                        out_chan, out_data, sb_exp[DATA_W], sb_exp[DATA_W-1:0]);
            end
         end
      end
      if (done === 1'b1) done_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; abort = 1'b0; mode_sel = 1'b0; n_samples = '0;
      write = 1'b0; data = '0; out_ready = 1'b0;
      tick(); tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
      checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
      checks++; if (out_chan !== 1'b0) begin failures++; $display("FAIL reset_chan got=%b exp=0", out_chan); end
      checks++; if (cnt_out1 !== '0 || cnt_out2 !== '0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cnt_out1, cnt_out2); end
      checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int d0;
      d0 = done_cnt;
      mode_sel = 1'b0; n_samples = 20'd4; out_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_rise got=%b exp=1", busy); end
      for (int i = 0; i < 4; i++) begin
         write = 1'b1; data = 32'h10 + i; exp_q.push_back({1'b0, data});
         tick();
      end
      write = 1'b0;
      for (int k = 0; k < 20 && done !== 1'b1; k++) tick();
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_done_timeout got=%b exp=1", done); end
      tick();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_end got done=%b busy=%b exp 0/0", done, busy); end
      checks++; if (cnt_out1 !== 20'd4 || cnt_out2 !== 20'd0) begin failures++; $display("FAIL basic_cnt got=%0d/%0d exp=4/0", cnt_out1, cnt_out2); end
      checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt - d0); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL basic_pending got=%0d exp=0", exp_q.size()); end
   endtask

   task automatic test_overflow();
      mode_sel = 1'b1; n_samples = 20'd12; out_ready = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         write = 1'b1; data = 32'h100 + i; exp_q.push_back({1'b1, data});
         tick();
         if (i == 6) begin
            checks++; if (stall !== 1'b0) begin failures++; $display("FAIL ovf_stall_at7 got=%b exp=0", stall); end
         end
      end
      write = 1'b0;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL ovf_stall_at8 got=%b exp=1", stall); end
      tick(); tick();
      checks++; if (stall !== 1'b1 || overflow !== 1'b0) begin failures++; $display("FAIL ovf_hold got stall=%b ovf=%b exp 1/0", stall, overflow); end
      write = 1'b1; data = 32'hDEAD0001;
      tick();
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
      // Second dropped write coincides with a pop: still refused.
      data = 32'hDEAD0002; out_ready = 1'b1;
      tick();
      write = 1'b0;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL ovf_push_pop_full got stall=%b exp=0", stall); end
      for (int k = 0; k < 20 && out_valid === 1'b1; k++) tick();
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL ovf_drained got pending=%0d exp=0", exp_q.size()); end
      checks++; if (cnt_out2 !== 20'd8 || cnt_out1 !== 20'd0 || busy !== 1'b1) begin
         failures++; $display("FAIL ovf_cnt8 got=%0d/%0d busy=%b exp=0/8 busy=1", cnt_out1, cnt_out2, busy);
      end
      for (int i = 0; i < 4; i++) begin
         write = 1'b1; data = 32'h200 + i; exp_q.push_back({1'b1, data});
         tick();
      end
      write = 1'b0;
      for (int k = 0; k < 20 && done !== 1'b1; k++) tick();
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL ovf_done_timeout got=%b exp=1", done); end
      tick();
      checks++; if (cnt_out2 !== 20'd12 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_final got cnt2=%0d ovf=%b exp 12/1", cnt_out2, overflow); end
   endtask

   task automatic test_zero_len();
      int d0;
      d0 = done_cnt;
      mode_sel = 1'b0; n_samples = 20'd0; out_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL zero_c1 got done=%b busy=%b exp 0/1", done, busy); end
      checks++; if (cnt_out2 !== '0 || overflow !== 1'b0) begin failures++; $display("FAIL zero_clear got cnt2=%0d ovf=%b exp 0/0", cnt_out2, overflow); end
      tick();
      checks++; if (done !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL zero_c2 got done=%b valid=%b exp 0/0", done, out_valid); end
      tick();
      checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL zero_c3 got done=%b valid=%b exp 1/0", done, out_valid); end
      tick();
      checks++; if (busy !== 1'b0 || done_cnt - d0 != 1 || cnt_out1 !== '0) begin
         failures++; $display("FAIL zero_end got busy=%b pulses=%0d cnt1=%0d exp 0/1/0", busy, done_cnt - d0, cnt_out1);
      end
   endtask

   task automatic test_mode_toggle();
      mode_sel = 1'b0; n_samples = 20'd6; out_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         write = 1'b1; data = 32'h300 + i; exp_q.push_back({1'b0, data});
         mode_sel = ~mode_sel;
         start = (i == 2);
         n_samples = 20'd2;
         tick();
      end
      write = 1'b0; start = 1'b0;
      for (int k = 0; k < 20 && done !== 1'b1; k++) tick();
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL mode_done_timeout got=%b exp=1", done); end
      tick();
      checks++; if (cnt_out1 !== 20'd6 || cnt_out2 !== 20'd0) begin failures++; $display("FAIL mode_cnt got=%0d/%0d exp=6/0", cnt_out1, cnt_out2); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL mode_pending got=%0d exp=0", exp_q.size()); end
   endtask

   task automatic test_abort();
      int d0;
      d0 = done_cnt;
      mode_sel = 1'b1; n_samples = 20'd8; out_ready = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         write = 1'b1; data = 32'h400 + i;
         tick();
      end
      write = 1'b0;
      checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL abort_pre got valid=%b busy=%b exp 1/1", out_valid, busy); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || dbg_state !== IDLE) begin
         failures++; $display("FAIL abort_next got busy=%b valid=%b state=%0d exp 0/0/0", busy, out_valid, dbg_state);
      end
      checks++; if (out_data !== '0 || stall !== 1'b0) begin failures++; $display("FAIL abort_outs got data=%h stall=%b exp 0/0", out_data, stall); end
      tick(); tick();
      out_ready = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0 || done_cnt != d0) begin failures++; $display("FAIL abort_after got valid=%b pulses=%0d exp 0/0", out_valid, done_cnt - d0); end
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_drain();
      mode_sel = 1'b0; n_samples = 20'd3; out_ready = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         write = 1'b1; data = 32'h500 + i; exp_q.push_back({1'b0, data});
         tick();
      end
      write = 1'b0;
      tick();
      checks++; if (dbg_state !== DRAIN) begin failures++; $display("FAIL rstd_in_drain got=%0d exp=2", dbg_state); end
      rst = 1'b0;
      tick();
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || stall !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
         failures++; $display("FAIL rstd_flags got busy=%b valid=%b stall=%b done=%b ovf=%b exp all 0", busy, out_valid, stall, done, overflow);
      end
      checks++; if (out_data !== '0 || out_chan !== 1'b0 || cnt_out1 !== '0 || cnt_out2 !== '0 || dbg_state !== IDLE) begin
         failures++; $display("FAIL rstd_values got data=%h chan=%b cnt=%0d/%0d state=%0d exp 0", out_data, out_chan, cnt_out1, cnt_out2, dbg_state);
      end
      exp_q.delete();
      rst = 1'b1;
      tick();
      mode_sel = 1'b1; n_samples = 20'd2; out_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         write = 1'b1; data = 32'h600 + i; exp_q.push_back({1'b1, data});
         tick();
      end
      write = 1'b0;
      for (int k = 0; k < 20 && done !== 1'b1; k++) tick();
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL rstd_fresh_timeout got=%b exp=1", done); end
      tick();
      checks++; if (cnt_out2 !== 20'd2 || cnt_out1 !== 20'd0 || exp_q.size() != 0) begin
         failures++; $display("FAIL rstd_fresh got cnt=%0d/%0d pending=%0d exp 0/2/0", cnt_out1, cnt_out2, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_zero_len();
      test_mode_toggle();
      test_abort();
      test_reset_mid_drain();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
